// File: rtl/sdram_dq_datapath.sv
// Burst-level DQ data path between the SDRAM command sequencer and the
// per-bit DQ pad buffers.
//   Write: serialises one wide burst onto dq_o/dq_oe/dqm. Beat 0 is driven
//          in the same cycle as start_wr, so it reaches the pads together
//          with the WRITE command through one output register stage.
//   Read:  a token shift register tracks CAS latency plus pad input delay.
//          Beats sampled from dq_i are assembled into rdata. rdata_valid
//          pulses for one cycle when rdata holds a complete burst.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_wr, start_rd  command-issue pulses from the sequencer
//   wdata, wmask        write burst and per-byte mask (beat 0 in LSBs, 1 = masked)
//   rdata, rdata_valid  assembled read burst and its one-cycle valid pulse
//   wr_busy             write beats are being driven
//   rd_inflight         read beats are still expected from the pads
//   protocol_err        sticky command-conflict flag
//   dq_o, dq_oe, dqm    to the pad output, output-enable and DQM registers
//   dq_i                from the pad input register
module sdram_dq_datapath #(
    parameter int unsigned W           = 16,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned CAS_LATENCY = 2,
    parameter int unsigned IN_DELAY    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_wr,
    input  logic                           start_rd,
    input  logic [W*BURST_LEN-1:0]         wdata,
    input  logic [BURST_LEN*(W/8)-1:0]     wmask,
    output logic [W*BURST_LEN-1:0]         rdata,
    output logic                           rdata_valid,
    output logic                           wr_busy,
    output logic                           rd_inflight,
    output logic                           protocol_err,
    output logic [W-1:0]                   dq_o,
    output logic [W-1:0]                   dq_oe,
    output logic [W/8-1:0]                 dqm,
    input  logic [W-1:0]                   dq_i
);

    localparam int unsigned BW     = W / 8;
    localparam int unsigned DW     = W * BURST_LEN;
    localparam int unsigned MW     = BW * BURST_LEN;
    localparam int unsigned RD_LAT = 1 + CAS_LATENCY + IN_DELAY;
    localparam int unsigned TOK_D  = RD_LAT + BURST_LEN;
    localparam int unsigned BC_W   = $clog2(BURST_LEN);
    // Token positions that sample dq_i: token i is set in cycle T+1+i
    localparam int unsigned S_LO   = RD_LAT - 1;
    localparam int unsigned S_HI   = RD_LAT + BURST_LEN - 2;
    // A read issued fewer than BURST_LEN cycles ago sits in these positions
    localparam int unsigned RC_HI  = BURST_LEN - 2;
    // Read beats are on the SDRAM bus while their token sits at index
    // CAS_LATENCY..CAS_LATENCY+BURST_LEN-1. A write is refused if any such
    // beat is still ahead of us within BURST_LEN+1 cycles.
    localparam int          TA_HI  = int'(CAS_LATENCY + BURST_LEN) - 1;
    localparam int          TA_LO  = int'(CAS_LATENCY) - int'(BURST_LEN) - 1;

    function automatic logic [TOK_D-1:0] ta_mask_f();
        logic [TOK_D-1:0] m;
        m = '0;
        for (int i = 0; i < int'(TOK_D); i++) begin
            if (i >= TA_LO && i <= TA_HI) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [TOK_D-1:0] TA_MASK = ta_mask_f();

    typedef enum logic {
        IDLE = 1'b0,
        WR   = 1'b1
    } wr_state_t;

    wr_state_t         state_q;
    logic [BC_W-1:0]   beat_q;
    logic [DW-1:0]     wdata_q;
    logic [MW-1:0]     wmask_q;
    logic [W-1:0]      dq_o_q;
    logic [TOK_D-1:0]  tok_q;
    logic [DW-1:0]     asm_q;

    logic              in_wr;
    logic              ta_conf;
    logic              rd_conf;
    logic              acc_wr;
    logic              err_set;
    logic              beat_en;
    logic              last_beat;
    logic [DW-1:0]     asm_nxt;

    // Command acceptance and conflict detection
    always_comb begin
        in_wr   = (state_q == WR);
        ta_conf = |(tok_q & TA_MASK);
        rd_conf = |tok_q[RC_HI:0];
        acc_wr  = start_wr && !in_wr && !start_rd && !ta_conf;
        err_set = (start_wr && (in_wr || start_rd || ta_conf)) ||
                  (start_rd && rd_conf);
    end

    // Pad drive: beat 0 straight from wdata on acceptance, then latched beats
    always_comb begin
        dq_o    = dq_o_q;
        dq_oe   = '0;
        dqm     = '1;
        wr_busy = 1'b0;
        if (acc_wr) begin
            dq_o    = wdata[W-1:0];
            dq_oe   = '1;
            dqm     = wmask[BW-1:0];
            wr_busy = 1'b1;
        end else if (in_wr) begin
            dq_o    = wdata_q[W-1:0];
            dq_oe   = '1;
            dqm     = wmask_q[BW-1:0];
            wr_busy = 1'b1;
        end
    end

    // Write FSM: the latched burst shifts down one beat per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            dq_o_q  <= '0;
        end else begin
            dq_o_q <= dq_o;
            case (state_q)
                IDLE: begin
                    if (acc_wr) begin
                        state_q <= WR;
                        beat_q  <= '0;
                        wdata_q <= wdata >> W;
                        wmask_q <= wmask >> BW;
                    end
                end
                WR: begin
                    wdata_q <= wdata_q >> W;
                    wmask_q <= wmask_q >> BW;
                    if (beat_q == BC_W'(BURST_LEN - 2)) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + BC_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read sampling windows and assembly (beat 0 ends up in the LSBs)
    always_comb begin
        beat_en   = |tok_q[S_HI:S_LO];
        last_beat = tok_q[S_HI];
        asm_nxt   = {dq_i, asm_q[DW-1:W]};
    end

    assign rd_inflight = |tok_q;

    // Read token pipeline, assembly register and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q        <= '0;
            asm_q        <= '0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            tok_q        <= {tok_q[TOK_D-2:0], start_rd};
            rdata_valid  <= last_beat;
            protocol_err <= protocol_err | err_set;
            if (beat_en) asm_q <= asm_nxt;
            if (last_beat) rdata <= asm_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_dq_datapath.sv
// Self-checking bench for sdram_dq_datapath (W=16, BURST_LEN=4, CL=2,
// IN_DELAY=2). Write beats and read bursts are pushed to scoreboards when
// issued and compared per cycle, at the falling edge, by a monitor.
module tb_sdram_dq_datapath;

    localparam int unsigned W      = 16;
    localparam int unsigned BL     = 4;
    localparam int unsigned CL     = 2;
    localparam int unsigned IND    = 2;
    localparam int unsigned BW     = W / 8;
    localparam int unsigned DW     = W * BL;
    localparam int unsigned MW     = BW * BL;
    localparam int          RD_LAT = 1 + int'(CL) + int'(IND);

    typedef struct {
        int            cyc;
        logic [W-1:0]  d;
        logic [BW-1:0] m;
    } wbeat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } rburst_t;

    logic          clk;
    logic          rst_n;
    logic          start_wr;
    logic          start_rd;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          wr_busy;
    logic          rd_inflight;
    logic          protocol_err;
    logic [W-1:0]  dq_o;
    logic [W-1:0]  dq_oe;
    logic [BW-1:0] dqm;
    logic [W-1:0]  dq_i;

    sdram_dq_datapath #(
        .W(W), .BURST_LEN(BL), .CAS_LATENCY(CL), .IN_DELAY(IND)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_wr(start_wr), .start_rd(start_rd),
        .wdata(wdata), .wmask(wmask),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .wr_busy(wr_busy), .rd_inflight(rd_inflight),
        .protocol_err(protocol_err),
        .dq_o(dq_o), .dq_oe(dq_oe), .dqm(dqm), .dq_i(dq_i)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    wbeat_t        wr_q[$];
    rburst_t       rd_q[$];
    bit            exp_infl[int];
    logic [W-1:0]  drive_at[int];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one cycle and drive dq_i for the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (drive_at.exists(cyc)) dq_i = drive_at[cyc];
        else dq_i = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sched_rd();
        logic [DW-1:0] e;
        int            c;
        e = '0;
        for (int k = 0; k < int'(BL); k++) begin
            c = cyc + RD_LAT + k;
            if (!drive_at.exists(c)) drive_at[c] = W'($urandom);
            e[k*W +: W] = drive_at[c];
        end
        rd_q.push_back('{cyc: cyc + RD_LAT + int'(BL), d: e});
        for (int j = 1; j <= RD_LAT + int'(BL); j++) exp_infl[cyc + j] = 1'b1;
    endtask

    // One command cycle; wr_ok says whether the bench expects the write accepted
    task automatic stim(input bit wr, input bit rd, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, input bit wr_ok);
        start_wr = wr;
        start_rd = rd;
        wdata    = wd;
        wmask    = wm;
        if (wr && wr_ok) begin
            for (int k = 0; k < int'(BL); k++)
                wr_q.push_back('{cyc: cyc + k, d: wd[k*W +: W], m: wm[k*BW +: BW]});
        end
        if (rd) sched_rd();
        tick();
        start_wr = 1'b0;
        start_rd = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dq_o"}, dq_o, 0);
        check({tag, "_dq_oe"}, dq_oe, 0);
        check({tag, "_dqm"}, dqm, 2'b11);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rvalid"}, rdata_valid, 0);
        check({tag, "_wr_busy"}, wr_busy, 0);
        check({tag, "_rd_infl"}, rd_inflight, 0);
        check({tag, "_perr"}, protocol_err, 0);
    endtask

    // Reset asserted mid-cycle; all pending expectations are discarded
    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst");
        wr_q.delete();
        rd_q.delete();
        exp_infl.delete();
        drive_at.delete();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Per-cycle scoreboard comparison
    always @(negedge clk) begin
        if (rst_n) begin
            bit      exp_beat;
            bit      exp_v;
            wbeat_t  wb;
            rburst_t rb;
            exp_beat = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            check("dq_oe", dq_oe, exp_beat ? 16'hFFFF : 16'h0000);
            check("wr_busy", wr_busy, exp_beat);
            if (exp_beat) begin
                wb = wr_q.pop_front();
                check("dq_o", dq_o, wb.d);
                check("dqm_wr", dqm, wb.m);
            end else begin
                check("dqm_idle", dqm, 2'b11);
            end
            exp_v = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            check("rdata_valid", rdata_valid, exp_v);
            if (exp_v) begin
                rb = rd_q.pop_front();
                check("rdata", rdata, rb.d);
            end
            check("rd_inflight", rd_inflight, exp_infl.exists(cyc));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        rst_n    = 1'b0;
        start_wr = 1'b0;
        start_rd = 1'b0;
        wdata    = '0;
        wmask    = '0;
        dq_i     = '0;
        idle(2);
        apply_reset(2);

        // Idle after reset
        idle(10);
        check("idle_perr", protocol_err, 0);
        check("idle_oe", dq_oe, 0);
        check("idle_dqm", dqm, 2'b11);

        // Single write with known pattern
        stim(1, 0, 64'h4444_3333_2222_1111, 8'h00, 1);
        idle(6);
        check("wr1_dq_o_hold", dq_o, 16'h4444);

        // Gapless writes at T and T+4, third at T+5 rejected
        stim(1, 0, rnd_data(), MW'($urandom), 1);
        idle(3);
        stim(1, 0, rnd_data(), MW'($urandom), 1);
        check("gapless_perr", protocol_err, 0);
        stim(1, 0, rnd_data(), MW'($urandom), 0);
        check("wr_busy_perr", protocol_err, 1);
        idle(6);

        apply_reset(2);
        check("clr_perr", protocol_err, 0);

        // Single read
        stim(0, 1, '0, '0, 0);
        idle(12);

        // Back-to-back reads, then a write in the turnaround window
        stim(0, 1, '0, '0, 0);
        idle(3);
        stim(0, 1, '0, '0, 0);
        idle(1);
        check("b2b_perr", protocol_err, 0);
        stim(1, 0, rnd_data(), '0, 0);
        check("ta_perr", protocol_err, 1);
        idle(12);

        // Mixed traffic without conflicts
        apply_reset(2);
        for (int i = 0; i < 4; i++) begin
            stim(1, 0, rnd_data(), MW'($urandom), 1);
            idle(3);
            stim(0, 1, '0, '0, 0);
            idle(3);
            stim(0, 1, '0, '0, 0);
            idle(12);
        end
        check("mixed_perr", protocol_err, 0);

        // Simultaneous write and read: write dropped, read tracked
        stim(1, 1, rnd_data(), '0, 0);
        check("same_cyc_perr", protocol_err, 1);
        idle(12);

        // Reads only two cycles apart: error, both still tracked
        apply_reset(2);
        stim(0, 1, '0, '0, 0);
        idle(1);
        stim(0, 1, '0, '0, 0);
        check("rd_close_perr", protocol_err, 1);
        idle(14);

        // Reset in the middle of a write burst
        apply_reset(2);
        d = 64'hDDDD_CCCC_BBBB_AAAA;
        stim(1, 0, d, 8'h5A, 1);
        tick();
        apply_reset(2);
        #1;
        check_reset_vals("post_rst");
        idle(8);

        // Reset while a read is pending
        stim(0, 1, '0, '0, 0);
        idle(3);
        apply_reset(2);
        idle(12);

        check("wr_q_left", 64'(wr_q.size()), 0);
        check("rd_q_left", 64'(rd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
